// File: rtl/mul_div_seq_divider_if.sv
// rtl/mul_div_seq_divider_if.sv - operand/result handshake bundle for the sequential divider
interface mul_div_seq_divider_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       div_op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] result;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    // Producer of operations and consumer of results
    modport master (
        output op_a, op_b, div_op, in_valid, out_ready,
        input  in_ready, result, out_valid, busy
    );

    // The divider itself
    modport slave (
        input  op_a, op_b, div_op, in_valid, out_ready,
        output in_ready, result, out_valid, busy
    );
endinterface

// File: rtl/mul_div_seq_divider.sv
// rtl/mul_div_seq_divider.sv - radix-2 restoring divider for DIV/DIVU/REM/REMU
module mul_div_seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mul_div_seq_divider_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIX    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rem_sel_q, rem_sel_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic [WIDTH-1:0] result_q, result_d;

    // Operand decode used only at accept
    logic             is_signed;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             b_zero;
    logic             ovf;

    // One restoring step: {rem, quo} shifted left, then trial subtract
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign is_signed = ~bus.div_op[0];
    // The most negative value keeps its bit pattern and is then read as an unsigned magnitude
    assign a_abs  = (is_signed && bus.op_a[WIDTH-1]) ? (~bus.op_a + 1'b1) : bus.op_a;
    assign b_abs  = (is_signed && bus.op_b[WIDTH-1]) ? (~bus.op_b + 1'b1) : bus.op_b;
    assign b_zero = (bus.op_b == '0);
    assign ovf    = is_signed && (bus.op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.op_b == '1);

    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvs_q};
    assign q_fix  = sign_q_q ? (~quo_q + 1'b1) : quo_q;
    assign r_fix  = sign_r_q ? (~rem_q + 1'b1) : rem_q;

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            rem_sel_q <= 1'b0;
            sign_q_q  <= 1'b0;
            sign_r_q  <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            rem_sel_q <= rem_sel_d;
            sign_q_q  <= sign_q_d;
            sign_r_q  <= sign_r_d;
            result_q  <= result_d;
        end
    end

    // Next-state logic: accept and special cases, one quotient bit per cycle, sign fix-up, hold
    always_comb begin
        state_d   = state_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        rem_sel_d = rem_sel_q;
        sign_q_d  = sign_q_q;
        sign_r_d  = sign_r_q;
        result_d  = result_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    rem_sel_d = bus.div_op[1];
                    sign_q_d  = is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                    sign_r_d  = is_signed & bus.op_a[WIDTH-1];
                    quo_d     = a_abs;
                    dvs_d     = b_abs;
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (b_zero) begin
                        result_d = bus.div_op[1] ? bus.op_a : '1;
                        state_d  = DONE;
                    end else if (ovf) begin
                        result_d = bus.div_op[1] ? '0 : bus.op_a;
                        state_d  = DONE;
                    end else begin
                        state_d  = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                // A clear top bit means the trial difference did not go negative
                quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                rem_d = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = rem_sel_q ? r_fix : q_fix;
                state_d  = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mul_div_seq_divider.sv
// tb/tb_mul_div_seq_divider.sv - directed self-checking bench for the sequential divider
module tb_mul_div_seq_divider;
    localparam int WIDTH = 32;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mul_div_seq_divider_if #(.WIDTH(WIDTH)) bus ();

    mul_div_seq_divider #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents one operation at a negedge; the following posedge is the accept edge
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.div_op   = op;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op_a     = 32'hDEAD_BEEF;
        bus.op_b     = 32'h0000_0001;
    endtask

    // Counts edges from the accept edge until out_valid is seen; bounded
    task automatic wait_done(output int lat);
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        start_op(op, a, b);
        wait_done(lat);
        check({tag, "_lat"}, lat, exp_lat);
        check(tag, bus.result, exp);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.div_op    = OP_DIVU;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_result",    bus.result, 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_in_ready",  32'(bus.in_ready), 32'h1);
        check("rst_busy",      32'(bus.busy), 32'h0);
        rst = 1'b0;

        run_op("divu_100_7",  OP_DIVU, 32'd100, 32'd7, 32'h0000_000E, 34);
        run_op("remu_100_7",  OP_REMU, 32'd100, 32'd7, 32'h0000_0002, 34);
        run_op("div_m7_2",    OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("rem_m7_2",    OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("divu_by0",    OP_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("div_by0",     OP_DIV,  32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem_by0",     OP_REM,  32'h1234_5678, 32'd0, 32'h1234_5678, 1);
        run_op("remu_by0",    OP_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);
        run_op("div_ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",     OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        run_op("div_min_2",   OP_DIV,  32'h8000_0000, 32'd2, 32'hC000_0000, 34);
        run_op("divu_big",    OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 34);

        // Backpressure: result held while out_ready stays low
        @(negedge clk);
        start_op(OP_DIVU, 32'd1000, 32'd10);
        wait_done(lat);
        check("bp_lat", lat, 34);
        for (int i = 0; i < 10; i++) begin
            check("bp_result",    bus.result, 32'd100);
            check("bp_in_ready",  32'(bus.in_ready), 32'h0);
            check("bp_out_valid", 32'(bus.out_valid), 32'h1);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_rel_in_ready",  32'(bus.in_ready), 32'h1);
        check("bp_rel_out_valid", 32'(bus.out_valid), 32'h0);
        start_op(OP_REMU, 32'd1000, 32'd7);
        check("bp_restart_busy", 32'(bus.busy), 32'h1);
        wait_done(lat);
        check("bp_restart_lat", lat, 34);
        check("bp_restart_res", bus.result, 32'd6);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;

        // Reset in the middle of a divide
        @(negedge clk);
        start_op(OP_DIVU, 32'd100, 32'd7);
        repeat (14) @(posedge clk);
        @(negedge clk);
        check("mid_busy_before", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_busy",      32'(bus.busy), 32'h0);
        check("mid_rst_in_ready",  32'(bus.in_ready), 32'h1);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("mid_rst_result",    bus.result, 32'h0);
        rst = 1'b0;
        run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 34);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
